reset_seq_multi: RTL and testbench
==================================

Name: reset_seq_multi

Overview:
- Parametrised multi-channel reset sequencer for PolarFire fabric.
- Qualifies external reset, PLL lock and device init-done, controls PLL powerdown, and releases NUM_CH fabric reset channels in a fixed staggered order after a programmable hold time.
- Adds per-channel software reset with pulse stretching and a lock-loss re-sequence.
- Sits at the top level between the PLL/init sources and the clock-domain logic it resets.

Parameters:
- NUM_CH, 4: number of reset output channels (1..16); channel 0 is released first.
- HOLD_CYCLES, 16: cycles all conditions must stay good before the first release (>=2).
- STAGGER_CYCLES, 8: cycles between consecutive channel releases; also the software-reset pulse length (>=1).
- LOCK_FILTER, 4: consecutive cycles synchronised PLL_LOCK must be high to count as locked (>=1).
- CNT_W, derived: $clog2 of max(HOLD_CYCLES, STAGGER_CYCLES, LOCK_FILTER) + 1.

Ports:
- CLK, input, 1: single clock, all logic on the rising edge.
- RST, input, 1: synchronous active-high reset.
- EXT_RST_N, input, 1: asynchronous board reset, active low; 2-flop synchronised internally.
- PLL_LOCK, input, 1: asynchronous PLL lock; 2-flop synchronised internally.
- INIT_DONE, input, 1: device init complete; synchronous to CLK.
- SW_RST_REQ, input, NUM_CH: per-channel soft-reset request; level-sampled each cycle.
- CH_RESET_N, output, NUM_CH: per-channel fabric reset, active low, registered.
- PLL_POWERDOWN_B, output, 1: PLL enable, active low powerdown, registered.
- ALL_READY, output, 1: high when in S_RUN and no channel is in soft reset.
- SEQ_STATE, output, 3: current state encoding, for debug.

Behaviour:
- Reset values while RST=1: CH_RESET_N all 0, PLL_POWERDOWN_B=0, ALL_READY=0, SEQ_STATE=S_OFF, all counters and synchronisers cleared.
- Synchronisers: ext_ok is the 2-flop-synchronised EXT_RST_N; lock_s is the 2-flop-synchronised PLL_LOCK.
- Lock filter: counter increments while lock_s=1 and saturates at LOCK_FILTER. lock_ok=1 when the counter equals LOCK_FILTER. lock_s=0 clears the counter, so lock_ok drops the next cycle.
- good = ext_ok & lock_ok & INIT_DONE.
- S_OFF: PLL_POWERDOWN_B=0. Leave to S_WAIT when ext_ok=1.
- S_WAIT: PLL_POWERDOWN_B=1 (registered, rises the cycle after entry). hold_cnt=0. Go to S_HOLD when good=1.
- S_HOLD: hold_cnt increments each cycle.
  - good=0 returns to S_WAIT.
  - At hold_cnt=HOLD_CYCLES-1, go to S_REL with idx=0 and stag_cnt=0.
- S_REL:
  - CH_RESET_N[idx] goes 1 in the first S_REL cycle for idx 0, then every STAGGER_CYCLES cycles for idx 1..NUM_CH-1.
  - S_RUN is entered STAGGER_CYCLES cycles after the last channel is released.
- S_RUN: ALL_READY = ~|soft_active.
- Fault priority, highest first: RST > ext_ok=0 > lock_ok=0 or INIT_DONE=0.
  - ext_ok=0 in any state: go to S_OFF and power the PLL down.
  - lock_ok=0 or INIT_DONE=0 in S_HOLD, S_REL or S_RUN: go to S_WAIT.
  - On every such transition, all CH_RESET_N go 0 on the next edge and ALL_READY=0.
- Soft reset, S_RUN only:
  - SW_RST_REQ[i]=1 loads channel i's stretch counter with STAGGER_CYCLES. CH_RESET_N[i]=0 while the counter is non-zero.
  - Re-assertion during a stretch reloads the counter (restart).
  - Requests outside S_RUN are ignored. Leaving S_RUN clears all stretch counters.
- Fault vs soft request: a fault and a soft request in the same cycle resolve to the fault.
- NUM_CH=1: S_REL lasts STAGGER_CYCLES cycles, then S_RUN.

Decomposition:
- Package reset_seq_pkg holds:
  - State enum: S_OFF=0, S_WAIT=1, S_HOLD=2, S_REL=3, S_RUN=4.
  - Width function for CNT_W.
- One sub-module, reset_stretch: a loadable down-counter for one channel (inputs load, clear; output active). Instantiated NUM_CH times via generate.
- 2-flop synchronisers are inline.

Test Plan:
- Power-up, defaults, all inputs good after RST drops at cycle 0:
  - PLL_POWERDOWN_B rises cycle 4.
  - CH_RESET_N[0] rises 16 cycles after S_HOLD entry.
  - CH_RESET_N[1..3] rise at +8, +16, +24.
  - ALL_READY rises 8 cycles after CH3.
- Lock glitch: PLL_LOCK low for 1 cycle during S_REL with idx=2 -> all CH_RESET_N=0 and SEQ_STATE=S_WAIT. Full re-sequence requires 4 lock cycles plus 16 hold cycles before CH0 releases again.
- EXT_RST_N low for 3 cycles in S_RUN -> SEQ_STATE=S_OFF, PLL_POWERDOWN_B=0, all channels 0. Recovery starts from S_OFF.
- Soft reset: SW_RST_REQ=4'b0100 for 1 cycle in S_RUN -> only CH_RESET_N[2] low for exactly 8 cycles, ALL_READY low over the same window. A second pulse at stretch cycle 5 extends the low time to 13 cycles.
- INIT_DONE low during S_HOLD at hold_cnt=10 -> returns to S_WAIT, hold_cnt restarts at 0, no channel released.
- RST asserted mid-S_REL -> every output at its reset value on the next edge.

Source files
------------

// File: rtl/reset_seq_multi_pkg.sv
// Shared types and helpers for the multi-channel reset sequencer.
package reset_seq_pkg;

   typedef enum logic [2:0] {
      S_OFF  = 3'd0,
      S_WAIT = 3'd1,
      S_HOLD = 3'd2,
      S_REL  = 3'd3,
      S_RUN  = 3'd4
   } seq_state_t;

   // Counter width wide enough for the largest of the three timing parameters.
   function automatic int cnt_width(input int hold, input int stag, input int filt);
      int m;
      m = hold;
      if (stag > m) m = stag;
      if (filt > m) m = filt;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/reset_seq_multi_stretch.sv
// Per-channel soft-reset stretcher: a loadable down-counter.
// expiring flags the last active cycle so the parent can register the
// channel reset without a one-cycle lag.
module reset_stretch #(
   parameter int LEN   = 8,
   parameter int CNT_W = 5
) (
   input  logic CLK,
   input  logic RST,
   input  logic load,
   input  logic clear,
   output logic active,
   output logic expiring
);

   logic [CNT_W-1:0] cnt;

   // Clear wins over load; a load during an active stretch restarts it.
   always_ff @(posedge CLK) begin
      if (RST || clear)
         cnt <= '0;
      else if (load)
         cnt <= CNT_W'(LEN);
      else if (cnt != '0)
         cnt <= cnt - CNT_W'(1);
   end

   assign active   = (cnt != '0);
   assign expiring = (cnt == CNT_W'(1));

endmodule

// File: rtl/reset_seq_multi.sv
// Multi-channel reset sequencer: qualifies board reset, PLL lock and
// init-done, drives PLL powerdown and releases channel resets in order.
//
// state  | meaning
// S_OFF  | board reset active, PLL powered down
// S_WAIT | PLL enabled, waiting for lock and init-done
// S_HOLD | all conditions good, counting the hold time
// S_REL  | releasing channels one every STAGGER_CYCLES
// S_RUN  | all channels out of reset, soft resets accepted
module reset_seq_multi
   import reset_seq_pkg::*;
#(
   parameter int NUM_CH         = 4,
   parameter int HOLD_CYCLES    = 16,
   parameter int STAGGER_CYCLES = 8,
   parameter int LOCK_FILTER    = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EXT_RST_N,
   input  logic              PLL_LOCK,
   input  logic              INIT_DONE,
   input  logic [NUM_CH-1:0] SW_RST_REQ,
   output logic [NUM_CH-1:0] CH_RESET_N,
   output logic              PLL_POWERDOWN_B,
   output logic              ALL_READY,
   output logic [2:0]        SEQ_STATE
);

   localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGGER_CYCLES, LOCK_FILTER);
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [CNT_W-1:0] LOCK_MAX  = CNT_W'(LOCK_FILTER);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);

   logic              ext_s1, ext_ok;
   logic              lock_s1, lock_s;
   logic [CNT_W-1:0]  lock_cnt;
   logic              lock_ok;
   logic              good;
   seq_state_t        state;
   logic [CNT_W-1:0]  hold_cnt;
   logic [CNT_W-1:0]  stag_cnt;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  idx_nxt;
   logic              in_run;
   logic              soft_clear;
   logic [NUM_CH-1:0] soft_load;
   logic [NUM_CH-1:0] soft_active;
   logic [NUM_CH-1:0] soft_expiring;
   logic [NUM_CH-1:0] soft_next;

   // Two-flop synchronisers for the asynchronous board reset and PLL lock.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ext_s1  <= 1'b0;
         ext_ok  <= 1'b0;
         lock_s1 <= 1'b0;
         lock_s  <= 1'b0;
      end else begin
         ext_s1  <= EXT_RST_N;
         ext_ok  <= ext_s1;
         lock_s1 <= PLL_LOCK;
         lock_s  <= lock_s1;
      end
   end

   // Lock filter: saturating run-length of synchronised lock, cleared on any drop.
   always_ff @(posedge CLK) begin
      if (RST || !lock_s)
         lock_cnt <= '0;
      else if (lock_cnt != LOCK_MAX)
         lock_cnt <= lock_cnt + CNT_W'(1);
   end

   assign lock_ok = (lock_cnt == LOCK_MAX);
   assign good    = ext_ok & lock_ok & INIT_DONE;
   assign in_run  = (state == S_RUN);
   assign idx_nxt = idx + IDX_W'(1);

   // A fault in the same cycle as a soft request wins: the request is dropped
   // and every stretch counter is cleared because S_RUN is being left.
   assign soft_clear = ~(in_run & good);
   assign soft_load  = SW_RST_REQ & {NUM_CH{in_run & good}};
   assign soft_next  = soft_load | (soft_active & ~soft_expiring);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      reset_stretch #(
         .LEN   (STAGGER_CYCLES),
         .CNT_W (CNT_W)
      ) u_stretch (
         .CLK      (CLK),
         .RST      (RST),
         .load     (soft_load[i]),
         .clear    (soft_clear),
         .active   (soft_active[i]),
         .expiring (soft_expiring[i])
      );
   end

   // Sequencer FSM with registered channel resets, PLL enable and ready flag.
   always_ff @(posedge CLK) begin
      if (RST || !ext_ok) begin
         state           <= S_OFF;
         hold_cnt        <= '0;
         stag_cnt        <= '0;
         idx             <= '0;
         CH_RESET_N      <= '0;
         PLL_POWERDOWN_B <= 1'b0;
         ALL_READY       <= 1'b0;
      end else begin
         PLL_POWERDOWN_B <= (state != S_OFF);
         case (state)
            S_OFF: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               hold_cnt <= '0;
               if (good) state <= S_HOLD;
            end
            S_HOLD: begin
               if (!good) begin
                  state      <= S_WAIT;
                  CH_RESET_N <= '0;
                  ALL_READY  <= 1'b0;
               end else if (hold_cnt == HOLD_LAST) begin
                  state      <= S_REL;
                  idx        <= '0;
                  stag_cnt   <= '0;
                  CH_RESET_N <= NUM_CH'(1);
               end else begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            S_REL: begin
               if (!good) begin
                  state      <= S_WAIT;
                  CH_RESET_N <= '0;
                  ALL_READY  <= 1'b0;
               end else if (stag_cnt == STAG_LAST) begin
                  stag_cnt <= '0;
                  if (idx == IDX_LAST) begin
                     state      <= S_RUN;
                     CH_RESET_N <= '1;
                     ALL_READY  <= 1'b1;
                  end else begin
                     idx                 <= idx_nxt;
                     CH_RESET_N[idx_nxt] <= 1'b1;
                  end
               end else begin
                  stag_cnt <= stag_cnt + CNT_W'(1);
               end
            end
            S_RUN: begin
               if (!good) begin
                  state      <= S_WAIT;
                  CH_RESET_N <= '0;
                  ALL_READY  <= 1'b0;
               end else begin
                  CH_RESET_N <= ~soft_next;
                  ALL_READY  <= ~|soft_next;
               end
            end
            default: begin
               state      <= S_OFF;
               CH_RESET_N <= '0;
               ALL_READY  <= 1'b0;
            end
         endcase
      end
   end

   assign SEQ_STATE = state;

endmodule

// File: tb/tb_reset_seq_multi.sv
// Scoreboard bench for reset_seq_multi: a timestamp-based reference model
// predicts the outputs after every edge; a monitor compares them.
module tb_reset_seq_multi;
   import reset_seq_pkg::*;

   localparam int N    = 4;
   localparam int H    = 16;
   localparam int S    = 8;
   localparam int LF   = 4;
   localparam int MAXC = 6000;

   logic         clk = 1'b0;
   logic         rst;
   logic         ext_rst_n;
   logic         pll_lock;
   logic         init_done;
   logic [N-1:0] sw_rst_req;
   logic [N-1:0] ch_reset_n;
   logic         pll_pd_b;
   logic         all_ready;
   logic [2:0]   seq_state;

   always #5 clk = ~clk;

   reset_seq_multi #(
      .NUM_CH(N), .HOLD_CYCLES(H), .STAGGER_CYCLES(S), .LOCK_FILTER(LF)
   ) dut (
      .CLK            (clk),
      .RST            (rst),
      .EXT_RST_N      (ext_rst_n),
      .PLL_LOCK       (pll_lock),
      .INIT_DONE      (init_done),
      .SW_RST_REQ     (sw_rst_req),
      .CH_RESET_N     (ch_reset_n),
      .PLL_POWERDOWN_B(pll_pd_b),
      .ALL_READY      (all_ready),
      .SEQ_STATE      (seq_state)
   );

   typedef struct packed {
      logic [N-1:0] ch;
      logic         pd;
      logic         rdy;
      logic [2:0]   st;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   edge_no = 0;

   // Input history, one entry per cycle.
   bit rst_h [MAXC];
   bit ext_h [MAXC];
   bit lock_h[MAXC];
   bit init_h[MAXC];

   // Model state: off / waiting / sequencing since m_hold (edge number).
   bit m_off = 1'b1;
   bit m_seq = 1'b0;
   int m_hold = 0;
   int m_soft_end[N];

   function automatic bit h_rst(input int c);
      return (c < 0) ? 1'b1 : rst_h[c];
   endfunction
   function automatic bit h_ext(input int c);
      return (c < 0) ? 1'b0 : ext_h[c];
   endfunction
   function automatic bit h_lock(input int c);
      return (c < 0) ? 1'b0 : lock_h[c];
   endfunction

   // A synchronised input seen in cycle c is the raw value two cycles back,
   // provided no reset occurred in between.
   function automatic bit ext_ok_at(input int c);
      return h_ext(c-2) & ~h_rst(c-1) & ~h_rst(c-2);
   endfunction
   function automatic bit lock_s_at(input int c);
      return h_lock(c-2) & ~h_rst(c-1) & ~h_rst(c-2);
   endfunction
   // Locked once the synchronised lock was high for the last LF cycles.
   function automatic bit lock_ok_at(input int c);
      for (int j = 1; j <= LF; j++)
         if (h_rst(c-j) || !lock_s_at(c-j)) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_step(input logic [N-1:0] sw);
      int   c, n, el;
      bit   eok, g, was_run, prev_off, quiet;
      exp_t x;
      c = cyc;
      n = cyc + 1;
      eok = ext_ok_at(c);
      g = eok & lock_ok_at(c) & init_h[c];
      was_run = m_seq && ((c - m_hold) >= H + N*S);
      prev_off = m_off;
      if (rst_h[c] || !eok) begin
         m_off = 1'b1;
         m_seq = 1'b0;
      end else if (m_off) begin
         m_off = 1'b0;
      end else if (!m_seq) begin
         if (g) begin
            m_seq  = 1'b1;
            m_hold = n;
         end
      end else if (!g) begin
         m_seq = 1'b0;
      end else if (was_run) begin
         for (int i = 0; i < N; i++)
            if (sw[i]) m_soft_end[i] = n + S;
      end
      if (!m_seq)
         for (int i = 0; i < N; i++) m_soft_end[i] = 0;

      el = n - m_hold;
      x.pd = !rst_h[c] && eok && !prev_off;
      if (m_off)                x.st = S_OFF;
      else if (!m_seq)          x.st = S_WAIT;
      else if (el < H)          x.st = S_HOLD;
      else if (el < H + N*S)    x.st = S_REL;
      else                      x.st = S_RUN;
      quiet = 1'b1;
      for (int i = 0; i < N; i++) begin
         x.ch[i] = m_seq && (el >= H + i*S) && (n >= m_soft_end[i]);
         if (n < m_soft_end[i]) quiet = 1'b0;
      end
      x.rdy = (x.st == S_RUN) && quiet;
      exp_q.push_back(x);
   endtask

   task automatic drive(input bit r, input bit e, input bit l, input bit i,
                        input logic [N-1:0] sw);
      @(negedge clk);
      rst = r; ext_rst_n = e; pll_lock = l; init_done = i; sw_rst_req = sw;
      rst_h[cyc] = r; ext_h[cyc] = e; lock_h[cyc] = l; init_h[cyc] = i;
      model_step(sw);
      cyc++;
   endtask

   task automatic idle(input int k);
      for (int j = 0; j < k; j++) drive(1'b0, 1'b1, 1'b1, 1'b1, '0);
   endtask

   // Good inputs until the model says the cycle about to be driven sits at
   // the given offset from S_HOLD entry.
   task automatic idle_until(input int target);
      int guard;
      guard = 0;
      while (!(m_seq && (cyc - m_hold == target)) && guard < 300) begin
         idle(1);
         guard++;
      end
      if (guard >= 300) begin
         errors++;
         $display("FAIL seq_timeout offset=%0d not reached, got none", target);
      end
   endtask

   // Monitor: compare every registered output after each edge.
   initial begin
      exp_t x, got;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            edge_no++;
            got.ch = ch_reset_n; got.pd = pll_pd_b; got.rdy = all_ready; got.st = seq_state;
            checks++;
            if (got !== x) begin
               errors++;
               $display("FAIL outputs edge %0d: got ch=%b pd=%b rdy=%b st=%0d, want ch=%b pd=%b rdy=%b st=%0d",
                        edge_no, got.ch, got.pd, got.rdy, got.st, x.ch, x.pd, x.rdy, x.st);
            end
         end
      end
   end

   initial begin
      int ext_lo, lock_lo, init_lo;
      logic [N-1:0] sw;
      bit r;
      for (int i = 0; i < N; i++) m_soft_end[i] = 0;
      rst = 1'b1; ext_rst_n = 1'b0; pll_lock = 1'b0; init_done = 1'b0; sw_rst_req = '0;

      // Reset, then power-up with everything good.
      repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
      idle(70);

      // Soft reset on channel 2, then a restart at stretch cycle 5.
      drive(1'b0, 1'b1, 1'b1, 1'b1, 4'b0100);
      idle(12);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 4'b0100);
      idle(3);
      drive(1'b0, 1'b1, 1'b1, 1'b1, 4'b0100);
      idle(16);

      // Board reset low for three cycles in S_RUN, then recovery.
      repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b1, '0);
      idle_until(H + 2*S + 3);
      // Lock glitch while channel 2 is being released.
      drive(1'b0, 1'b1, 1'b0, 1'b1, '0);
      idle_until(10);
      // Init-done drop at hold count 10.
      drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
      idle_until(H + S + 2);
      // Synchronous reset mid-release.
      drive(1'b1, 1'b1, 1'b1, 1'b1, '0);
      idle(80);

      // Randomised fault and soft-request traffic.
      ext_lo = 0; lock_lo = 0; init_lo = 0;
      for (int k = 0; k < 3000; k++) begin
         if (ext_lo == 0 && $urandom_range(0, 399) == 0) ext_lo = $urandom_range(1, 4);
         if (lock_lo == 0 && $urandom_range(0, 199) == 0) lock_lo = $urandom_range(1, 3);
         if (init_lo == 0 && $urandom_range(0, 249) == 0) init_lo = $urandom_range(1, 5);
         r = ($urandom_range(0, 999) == 0);
         for (int i = 0; i < N; i++) sw[i] = ($urandom_range(0, 29) == 0);
         drive(r, ext_lo == 0, lock_lo == 0, init_lo == 0, sw);
         if (ext_lo > 0) ext_lo--;
         if (lock_lo > 0) lock_lo--;
         if (init_lo > 0) init_lo--;
      end

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
